// File: rtl/rv_div_req_ctrl.sv
// Request-side controller for the serial divider: one DIV/DIVU/REM/REMU op in flight,
// RISC-V divide-by-zero/overflow overrides per lane. Optional macro RV_DIV_FASTPATH_EN.
module rv_div_req_ctrl #(
  parameter int XLEN  = 32,
  parameter int LANES = 1,
  parameter int TAGW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [LANES*XLEN-1:0] req_a,
  input  logic [LANES*XLEN-1:0] req_b,
  input  logic [TAGW-1:0]       req_tag,
  output logic                  div_valid,
  input  logic                  div_ready,
  output logic [LANES*XLEN-1:0] div_numer,
  output logic [LANES*XLEN-1:0] div_denom,
  output logic                  div_signed,
  output logic [TAGW-1:0]       div_tag,
  input  logic                  div_rsp_valid,
  output logic                  div_rsp_ready,
  input  logic [LANES*XLEN-1:0] div_quotient,
  input  logic [LANES*XLEN-1:0] div_remainder,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LANES*XLEN-1:0] rsp_data,
  output logic [TAGW-1:0]       rsp_tag
);

  localparam int W = LANES * XLEN;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      data_q, data_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [LANES-1:0]  zdiv_q, zdiv_d;
  logic [LANES-1:0]  ovf_q, ovf_d;

  logic [LANES-1:0]  in_zdiv_s;
  logic [LANES-1:0]  in_ovf_s;
  logic [W-1:0]      cap_data_s;
`ifdef RV_DIV_FASTPATH_EN
  logic [W-1:0]      fast_data_s;
`endif

  // Architectural result for one lane; overrides win over whatever the divider produced.
  function automatic logic [XLEN-1:0] lane_result(
    input logic            is_rem,
    input logic            zdiv,
    input logic            ovf,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem
  );
    logic [XLEN-1:0] r;
    if (zdiv) begin
      r = is_rem ? a : {XLEN{1'b1}};
    end else if (ovf) begin
      r = is_rem ? {XLEN{1'b0}} : a;
    end else begin
      r = is_rem ? rem : quo;
    end
    return r;
  endfunction

  // Per-lane special flags of the incoming request and result selection at capture.
  always_comb begin
    in_zdiv_s  = {LANES{1'b0}};
    in_ovf_s   = {LANES{1'b0}};
    cap_data_s = {W{1'b0}};
`ifdef RV_DIV_FASTPATH_EN
    fast_data_s = {W{1'b0}};
`endif
    for (int m = 0; m < LANES; m++) begin
      in_zdiv_s[m] = (req_b[m*XLEN +: XLEN] == {XLEN{1'b0}});
      in_ovf_s[m]  = ~req_op[0]
                   && (req_a[m*XLEN +: XLEN] == {1'b1, {(XLEN-1){1'b0}}})
                   && (req_b[m*XLEN +: XLEN] == {XLEN{1'b1}});
      cap_data_s[m*XLEN +: XLEN] = lane_result(op_q[1], zdiv_q[m], ovf_q[m], a_q[m*XLEN +: XLEN],
                                               div_quotient[m*XLEN +: XLEN],
                                               div_remainder[m*XLEN +: XLEN]);
`ifdef RV_DIV_FASTPATH_EN
      fast_data_s[m*XLEN +: XLEN] = lane_result(req_op[1], in_zdiv_s[m], in_ovf_s[m],
                                                req_a[m*XLEN +: XLEN], {XLEN{1'b0}}, {XLEN{1'b0}});
`endif
    end
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    zdiv_d  = zdiv_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          a_d    = req_a;
          b_d    = req_b;
          tag_d  = req_tag;
          zdiv_d = in_zdiv_s;
          ovf_d  = in_ovf_s;
`ifdef RV_DIV_FASTPATH_EN
          // Every lane is fully determined by its override: skip the divider entirely.
          if (&(in_zdiv_s | in_ovf_s)) begin
            data_d  = fast_data_s;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (div_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (div_rsp_valid) begin
          data_d  = cap_data_s;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      tag_q   <= {TAGW{1'b0}};
      zdiv_q  <= {LANES{1'b0}};
      ovf_q   <= {LANES{1'b0}};
      data_q  <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      zdiv_q  <= zdiv_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign div_valid     = (state_q == S_ISSUE);
  assign div_rsp_ready = (state_q == S_WAIT);
  assign rsp_valid     = (state_q == S_RESP);
  assign div_numer     = a_q;
  assign div_denom     = b_q;
  assign div_signed    = ~op_q[0];
  assign div_tag       = tag_q;
  assign rsp_data      = data_q;
  assign rsp_tag       = tag_q;

endmodule

// File: tb/tb_rv_div_req_ctrl.sv
// Bench for rv_div_req_ctrl (LANES=2): fixed vector table, handshake corner sequences,
// and random ops checked against arithmetic RISC-V divide semantics; the bench plays the divider.
module tb_rv_div_req_ctrl;

  localparam int XLEN  = 32;
  localparam int LANES = 2;
  localparam int TAGW  = 4;
  localparam int W     = LANES * XLEN;
`ifdef RV_DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_ready;
  logic [1:0]      req_op;
  logic [W-1:0]    req_a, req_b;
  logic [TAGW-1:0] req_tag;
  logic            div_valid, div_ready;
  logic [W-1:0]    div_numer, div_denom;
  logic            div_signed;
  logic [TAGW-1:0] div_tag;
  logic            div_rsp_valid, div_rsp_ready;
  logic [W-1:0]    div_quotient, div_remainder;
  logic            rsp_valid, rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [TAGW-1:0] rsp_tag;

  int n_vec  = 0;
  int n_miss = 0;

  rv_div_req_ctrl #(.XLEN(XLEN), .LANES(LANES), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_valid(div_valid), .div_ready(div_ready), .div_numer(div_numer),
    .div_denom(div_denom), .div_signed(div_signed), .div_tag(div_tag),
    .div_rsp_valid(div_rsp_valid), .div_rsp_ready(div_rsp_ready),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [TAGW-1:0] tag;
    int              dd;
    int              dr;
    logic [W-1:0]    exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V result of one lane, straight from the ISA rules.
  function automatic logic [31:0] ref_lane(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit rem_op = op[1];
    bit sgn = (op[0] == 1'b0);
    if (b == 32'd0) return rem_op ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem_op ? 32'd0 : a;
    if (sgn) return rem_op ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem_op ? a % b : a / b;
  endfunction

  // Divider model: honest results for normal lanes, junk where the controller must override.
  task automatic div_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
    logic [31:0] al, bl;
    for (int l = 0; l < LANES; l++) begin
      al = a[l*32 +: 32];
      bl = b[l*32 +: 32];
      if (is_special(op, al, bl)) begin
        q[l*32 +: 32] = $urandom;
        r[l*32 +: 32] = $urandom;
      end else if (op[0] == 1'b0) begin
        q[l*32 +: 32] = 32'($signed(al) / $signed(bl));
        r[l*32 +: 32] = 32'($signed(al) % $signed(bl));
      end else begin
        q[l*32 +: 32] = al / bl;
        r[l*32 +: 32] = al % bl;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TAGW-1:0] tag, input int dd, input int dr, input logic [W-1:0] exp);
    bit fast;
    int n;
    logic [W-1:0] q, r;
    logic exp_sgn;
    exp_sgn = (op == 2'b00 || op == 2'b10);
    fast = FAST;
    for (int l = 0; l < LANES; l++) begin
      if (!is_special(op, a[l*32 +: 32], b[l*32 +: 32])) fast = 1'b0;
    end
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_idle", W'(req_ready), W'(1));
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_tag = ~tag;
    chk("req_ready_busy", W'(req_ready), W'(0));
    if (fast) begin
      chk("fast_rsp_valid", W'(rsp_valid), W'(1));
      chk("fast_div_valid", W'(div_valid), W'(0));
    end else begin
      for (int i = 0; i <= dd; i++) begin
        chk("div_valid", W'(div_valid), W'(1));
        chk("div_numer", div_numer, a);
        chk("div_denom", div_denom, b);
        chk("div_tag", W'(div_tag), W'(tag));
        chk("div_signed", W'(div_signed), W'(exp_sgn));
        chk("req_ready_issue", W'(req_ready), W'(0));
        chk("rsp_valid_issue", W'(rsp_valid), W'(0));
        if (i == dd) div_ready = 1'b1;
        @(posedge clk); #1;
        div_ready = 1'b0;
      end
      chk("div_valid_drop", W'(div_valid), W'(0));
      chk("div_rsp_ready", W'(div_rsp_ready), W'(1));
      div_model(op, a, b, q, r);
      div_quotient = q; div_remainder = r; div_rsp_valid = 1'b1;
      #1;
      chk("rsp_valid_no_comb", W'(rsp_valid), W'(0));
      @(posedge clk); #1;
      div_rsp_valid = 1'b0;
      div_quotient = {$urandom, $urandom}; div_remainder = {$urandom, $urandom};
      chk("rsp_valid", W'(rsp_valid), W'(1));
      chk("div_rsp_ready_drop", W'(div_rsp_ready), W'(0));
    end
    for (int i = 0; i <= dr; i++) begin
      chk("rsp_data", rsp_data, exp);
      chk("rsp_tag", W'(rsp_tag), W'(tag));
      chk("req_ready_resp", W'(req_ready), W'(0));
      chk("div_valid_resp", W'(div_valid), W'(0));
      if (i == dr) rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    chk("single_rsp", W'(rsp_valid), W'(0));
    chk("turnaround", W'(req_ready), W'(1));
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb, rexp;
    logic [31:0]  pool [5];

    tbl[0]  = '{2'b01, {32'd50, 32'd100}, {32'd5, 32'd7}, 4'd1, 0, 0, {32'd10, 32'd14}};
    tbl[1]  = '{2'b11, {32'd50, 32'd100}, {32'd5, 32'd7}, 4'd2, 0, 0, {32'd0, 32'd2}};
    tbl[2]  = '{2'b00, {32'd20, 32'hFFFF_FFF9}, {32'hFFFF_FFFE, 32'd2}, 4'd3, 1, 0, {32'hFFFF_FFF6, 32'hFFFF_FFFD}};
    tbl[3]  = '{2'b10, {32'd20, 32'hFFFF_FFF9}, {32'hFFFF_FFFE, 32'd2}, 4'd4, 0, 1, {32'd0, 32'hFFFF_FFFF}};
    tbl[4]  = '{2'b00, {32'd7, 32'd5}, {32'd0, 32'd0}, 4'd5, 0, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFF}};
    tbl[5]  = '{2'b10, {32'd7, 32'd5}, {32'd0, 32'd0}, 4'd6, 0, 0, {32'd7, 32'd5}};
    tbl[6]  = '{2'b00, {32'd9, 32'h8000_0000}, {32'd3, 32'hFFFF_FFFF}, 4'd7, 0, 0, {32'd3, 32'h8000_0000}};
    tbl[7]  = '{2'b10, {32'd9, 32'h8000_0000}, {32'd3, 32'hFFFF_FFFF}, 4'd8, 0, 0, {32'd0, 32'd0}};
    tbl[8]  = '{2'b00, {32'h8000_0000, 32'h8000_0000}, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'd9, 0, 0,
                {32'h8000_0000, 32'h8000_0000}};
    tbl[9]  = '{2'b10, {32'd11, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF}, 4'd10, 0, 0, {32'd11, 32'd0}};
    tbl[10] = '{2'b01, {32'h8000_0000, 32'h8000_0000}, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'd11, 0, 0, {32'd0, 32'd0}};
    tbl[11] = '{2'b11, {32'h8000_0000, 32'h8000_0000}, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'd12, 0, 0,
                {32'h8000_0000, 32'h8000_0000}};
    tbl[12] = '{2'b01, {32'd1000, 32'd100}, {32'd10, 32'd7}, 4'd13, 5, 3, {32'd100, 32'd14}};
    tbl[13] = '{2'b11, {32'd3, 32'hFFFF_FFFF}, {32'd0, 32'd16}, 4'd14, 2, 2, {32'd3, 32'd15}};

    pool[0] = 32'd0; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'd1; pool[4] = 32'd3;

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; req_tag = '0;
    div_ready = 1'b0; div_rsp_valid = 1'b0; div_quotient = '0; div_remainder = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_div_valid", W'(div_valid), W'(0));
    chk("rst_div_rsp_ready", W'(div_rsp_ready), W'(0));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_data", rsp_data, W'(0));
    chk("rst_rsp_tag", W'(rsp_tag), W'(0));

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].dd, tbl[i].dr, tbl[i].exp);
    end

    for (int k = 0; k < 60; k++) begin
      rop = 2'($urandom_range(0, 3));
      for (int l = 0; l < LANES; l++) begin
        ra[l*32 +: 32] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : 32'($urandom);
        rb[l*32 +: 32] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : 32'($urandom_range(1, 2000));
        if ($urandom_range(0, 3) == 0) rb[l*32 +: 32] = 32'($urandom);
        rexp[l*32 +: 32] = ref_lane(rop, ra[l*32 +: 32], rb[l*32 +: 32]);
      end
      run_op(rop, ra, rb, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), rexp);
    end

    // Reset while waiting on the divider response.
    req_valid = 1'b1; req_op = 2'b00; req_a = {32'd9, 32'd9}; req_b = {32'd3, 32'd3}; req_tag = 4'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; div_ready = 1'b1;
    @(posedge clk); #1;
    div_ready = 1'b0;
    chk("wait_before_reset", W'(div_rsp_ready), W'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_req_ready", W'(req_ready), W'(1));
    chk("mid_rst_div_valid", W'(div_valid), W'(0));
    chk("mid_rst_div_rsp_ready", W'(div_rsp_ready), W'(0));
    chk("mid_rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("mid_rst_rsp_data", rsp_data, W'(0));
    chk("mid_rst_rsp_tag", W'(rsp_tag), W'(0));
    run_op(2'b01, {32'd100, 32'd100}, {32'd7, 32'd9}, 4'd15, 0, 0, {32'd14, 32'd11});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
